// File: rtl/link_parameter_loader_pkg.sv
// Shared stage codes and boundary-condition encodings used by the loader and the neighbor links.
package link_parameter_loader_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RUNNING             = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT         = 3'd4;

  localparam logic [1:0] BOUNDARY_NONE    = 2'd0;
  localparam logic [1:0] BOUNDARY_EDGE    = 2'd1;
  localparam logic [1:0] BOUNDARY_ABSENT  = 2'd2;
  localparam logic [1:0] BOUNDARY_ILLEGAL = 2'd3;

endpackage

// File: rtl/link_param_sanitize.sv
// Combinational clean-up of one parameter word: clamps the weight and replaces an illegal boundary code.
module link_param_sanitize
  import link_parameter_loader_pkg::*;
#(
  parameter int  MAX_WEIGHT     = 2,
  localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
  localparam int WORD_WIDTH     = LINK_BIT_WIDTH + 2
) (
  input  logic [WORD_WIDTH-1:0] raw_word,
  output logic [WORD_WIDTH-1:0] clean_word,
  output logic [1:0]            err
);

  localparam logic [LINK_BIT_WIDTH-1:0] MAX_W = LINK_BIT_WIDTH'(MAX_WEIGHT);

  logic [LINK_BIT_WIDTH-1:0] raw_weight;
  logic [1:0]                raw_boundary;
  logic [LINK_BIT_WIDTH-1:0] weight;
  logic [1:0]                boundary;

  assign raw_weight   = raw_word[LINK_BIT_WIDTH-1:0];
  assign raw_boundary = raw_word[LINK_BIT_WIDTH +: 2];

  always_comb begin
    weight   = raw_weight;
    boundary = raw_boundary;
    err      = 2'b00;
    if (raw_weight > MAX_W) begin
      weight = MAX_W;
      err[0] = 1'b1;
    end
    // An illegal code is treated as a link that does not exist.
    if (raw_boundary == BOUNDARY_ILLEGAL) begin
      boundary = BOUNDARY_ABSENT;
      err[1]   = 1'b1;
    end
  end

  assign clean_word = {boundary, weight};

endmodule

// File: rtl/link_parameter_loader.sv
// Streams one sanitised parameter word per link into a shadow array and exposes it as flat link buses.
module link_parameter_loader
  import link_parameter_loader_pkg::*;
#(
  parameter int  NUM_LINKS      = 64,
  parameter int  MAX_WEIGHT     = 2,
  localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
  localparam int WORD_WIDTH     = LINK_BIT_WIDTH + 2,
  localparam int COUNT_WIDTH    = $clog2(NUM_LINKS + 1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [STAGE_WIDTH-1:0]              global_stage,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [WORD_WIDTH-1:0]               in_data,
  output logic                                in_ready,
  output logic                                params_ready,
  output logic                                done,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
  output logic [NUM_LINKS*2-1:0]              boundary_bus,
  output logic [COUNT_WIDTH-1:0]              link_count,
  output logic [2:0]                          error_flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_READY,
    S_APPLY
  } state_e;

  state_e state, state_nxt;
  logic   done_nxt;
  logic   stage_loading;
  logic   handshake;
  logic   last_word;
  logic   [WORD_WIDTH-1:0] clean_word;
  logic   [1:0]            san_err;

  assign stage_loading = (global_stage == STAGE_PARAMETERS_LOADING);
  assign in_ready      = (state == S_RECEIVE);
  assign params_ready  = (state == S_READY) || (state == S_APPLY);
  assign handshake     = in_valid && in_ready;
  assign last_word     = handshake && (link_count == COUNT_WIDTH'(NUM_LINKS - 1));

  link_param_sanitize #(
    .MAX_WEIGHT (MAX_WEIGHT)
  ) u_sanitize (
    .raw_word   (in_data),
    .clean_word (clean_word),
    .err        (san_err)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RECEIVE;
      S_RECEIVE: if (last_word) state_nxt = S_READY;
      S_READY:   if (stage_loading) state_nxt = S_APPLY;
      S_APPLY: begin
        if (!stage_loading) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      link_count  <= '0;
      error_flags <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (state == S_IDLE && start) begin
        link_count  <= '0;
        error_flags <= '0;
      end else begin
        if (handshake && link_count != COUNT_WIDTH'(NUM_LINKS))
          link_count <= link_count + 1'b1;
        // A loading stage seen mid-receive means links latched a partial set.
        error_flags <= error_flags
                     | {(state == S_RECEIVE) && stage_loading, 2'b00}
                     | {1'b0, handshake ? san_err : 2'b00};
      end
    end
  end

  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_shadow
    logic [WORD_WIDTH-1:0] shadow_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        shadow_q <= '0;
      else if (handshake && link_count == COUNT_WIDTH'(i))
        shadow_q <= clean_word;
    end

    assign weight_bus[i*LINK_BIT_WIDTH +: LINK_BIT_WIDTH] = shadow_q[LINK_BIT_WIDTH-1:0];
    assign boundary_bus[i*2 +: 2]                         = shadow_q[LINK_BIT_WIDTH +: 2];
  end

endmodule

// File: tb/tb_link_parameter_loader.sv
// Directed bench for link_parameter_loader with a per-cycle reference model and literal spot checks.
module tb_link_parameter_loader;
  import link_parameter_loader_pkg::*;

  localparam int N   = 4;
  localparam int MW  = 2;
  localparam int LBW = 2;
  localparam int CW  = 3;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [STAGE_WIDTH-1:0] global_stage = STAGE_IDLE;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic [LBW+1:0]       in_data = '0;
  logic                 in_ready, params_ready, done;
  logic [N*LBW-1:0]     weight_bus;
  logic [N*2-1:0]       boundary_bus;
  logic [CW-1:0]        link_count;
  logic [2:0]           error_flags;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  link_parameter_loader #(.NUM_LINKS(N), .MAX_WEIGHT(MW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .global_stage (global_stage),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .params_ready (params_ready),
    .done         (done),
    .weight_bus   (weight_bus),
    .boundary_bus (boundary_bus),
    .link_count   (link_count),
    .error_flags  (error_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 receiving, 2 set staged, 3 being applied.
  int         m_mode = 0;
  int         m_cnt = 0;
  logic [2:0] m_err = '0;
  bit         m_done = 1'b0;
  logic [1:0] m_w [N];
  logic [1:0] m_b [N];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_cnt = 0; m_err = '0; m_done = 1'b0;
      for (int i = 0; i < N; i++) begin m_w[i] = '0; m_b[i] = '0; end
    end else begin
      m_done = 1'b0;
      case (m_mode)
        0: if (start) begin m_cnt = 0; m_err = '0; m_mode = 1; end
        1: begin
          if (global_stage == STAGE_PARAMETERS_LOADING) m_err[2] = 1'b1;
          if (in_valid) begin
            int w, b;
            w = int'(in_data[1:0]);
            b = int'(in_data[3:2]);
            if (w > MW) begin w = MW; m_err[0] = 1'b1; end
            if (b == 3) begin b = 2; m_err[1] = 1'b1; end
            m_w[m_cnt] = 2'(w);
            m_b[m_cnt] = 2'(b);
            m_cnt++;
            if (m_cnt == N) m_mode = 2;
          end
        end
        2: if (global_stage == STAGE_PARAMETERS_LOADING) m_mode = 3;
        default: if (global_stage != STAGE_PARAMETERS_LOADING) begin m_mode = 0; m_done = 1'b1; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N*LBW-1:0] ewb;
      logic [N*2-1:0]   ebb;
      for (int i = 0; i < N; i++) begin
        ewb[i*LBW +: LBW] = m_w[i];
        ebb[i*2 +: 2]     = m_b[i];
      end
      check("m_in_ready", in_ready, m_mode == 1);
      check("m_params_ready", params_ready, (m_mode == 2) || (m_mode == 3));
      check("m_done", done, m_done);
      check("m_weight_bus", weight_bus, ewb);
      check("m_boundary_bus", boundary_bus, ebb);
      check("m_link_count", link_count, m_cnt);
      check("m_error_flags", error_flags, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int b, input int w);
    in_valid = 1'b1;
    in_data  = {2'(b), 2'(w)};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_set();
    global_stage = STAGE_PARAMETERS_LOADING;
    tick();
    global_stage = STAGE_MEASUREMENT_LOADING;
    tick();
    tick();
  endtask

  initial begin
    int counts[6] = '{1, 1, 2, 3, 3, 4};
    bit vals[6]   = '{1, 0, 1, 1, 0, 1};
    int dpulses;

    tick(); tick();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    check("rst_link_count", link_count, 0);
    check("rst_error_flags", error_flags, 0);
    check("rst_weight_bus", weight_bus, 0);
    check("rst_in_ready", in_ready, 0);

    // 1: clean set streamed back-to-back
    do_start();
    send(0, 1); send(1, 2); send(2, 0);
    check("t1_not_ready_yet", params_ready, 0);
    send(0, 2);
    check("t1_params_ready", params_ready, 1);
    check("t1_weight_bus", weight_bus, 8'h89);
    check("t1_boundary_bus", boundary_bus, 8'h24);
    check("t1_error_flags", error_flags, 0);

    // 2: apply window, done pulses once after the stage leaves loading
    global_stage = STAGE_PARAMETERS_LOADING;
    tick(); tick(); tick();
    check("t2_done_held_low", done, 0);
    global_stage = STAGE_MEASUREMENT_LOADING;
    dpulses = 0;
    tick();
    check("t2_done_pulse", done, 1);
    for (int k = 0; k < 4; k++) begin
      if (done) dpulses++;
      tick();
    end
    check("t2_done_count", dpulses, 1);
    check("t2_idle_params_ready", params_ready, 0);
    check("t2_weight_bus_held", weight_bus, 8'h89);
    check("t2_boundary_bus_held", boundary_bus, 8'h24);

    // 3: out-of-range weight and illegal boundary on link 1
    do_start();
    check("t3_flags_cleared", error_flags, 0);
    send(0, 0); send(3, 3); send(1, 1); send(0, 2);
    check("t3_slice1_weight", weight_bus[3:2], 2);
    check("t3_slice1_boundary", boundary_bus[3:2], 2);
    check("t3_error_flags", error_flags, 3'b011);
    check("t3_weight_bus", weight_bus, 8'h98);
    check("t3_boundary_bus", boundary_bus, 8'h18);
    apply_set();

    // 4: gapped valid, words ignored outside receive
    in_valid = 1'b1; in_data = 4'b0101;
    tick();
    in_valid = 1'b0;
    check("t4_idle_no_accept", link_count, 4);
    check("t4_idle_bus_same", weight_bus, 8'h98);
    do_start();
    check("t4_count_zero", link_count, 0);
    for (int j = 0; j < 6; j++) begin
      in_valid = vals[j];
      in_data  = {2'b00, 2'(j % 3)};
      tick();
      check($sformatf("t4_count_%0d", j), link_count, counts[j]);
    end
    in_valid = 1'b1; in_data = 4'b0101;
    tick();
    in_valid = 1'b0;
    check("t4_ready_no_accept", link_count, 4);
    check("t4_weight_bus", weight_bus, 8'h88);
    check("t4_params_ready", params_ready, 1);
    apply_set();

    // 5: loading stage arrives while receiving
    do_start();
    send(0, 1); send(1, 1);
    global_stage = STAGE_PARAMETERS_LOADING;
    tick();
    global_stage = STAGE_IDLE;
    check("t5_early_flag", error_flags, 3'b100);
    check("t5_still_receiving", in_ready, 1);
    send(0, 2); send(2, 0);
    check("t5_ready", params_ready, 1);
    check("t5_count", link_count, 4);
    check("t5_weight_bus", weight_bus, 8'h25);
    check("t5_boundary_bus", boundary_bus, 8'h84);
    apply_set();

    // 6: reset in the middle of a set
    do_start();
    send(1, 2); send(1, 2); send(1, 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_rst_count", link_count, 0);
    check("t6_rst_weight_bus", weight_bus, 0);
    check("t6_rst_boundary_bus", boundary_bus, 0);
    check("t6_rst_in_ready", in_ready, 0);
    do_start();
    send(0, 1); send(1, 0); send(0, 0); send(2, 1);
    check("t6_weight_bus", weight_bus, 8'h41);
    check("t6_boundary_bus", boundary_bus, 8'h84);
    check("t6_ready", params_ready, 1);
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
